// File: rtl/next_kbd_link.sv
// NeXT keyboard/mouse serial link controller: round-robin device polling, LED frames, event FIFO.
// Optional NEXT_KBD_RX_MAJORITY_EN: 3-sample majority per RX bit and 4-cycle start qualification.
module next_kbd_link #(
  parameter int BIT_CLKS        = 265,
  parameter int NUM_DEV         = 2,
  parameter int FIFO_DEPTH      = 4,
  parameter int LED_W           = 2,
  parameter int GAP_BITS        = 3,
  parameter int RX_TIMEOUT_BITS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               led_valid,
  input  logic [LED_W-1:0]   led_data,
  output logic               led_ready,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_dev,
  output logic [15:0]        evt_data,
  output logic               fifo_overflow,
  output logic [NUM_DEV-1:0] dev_present,
  input  logic               from_kb,
  output logic               to_kb
);
  localparam int CW   = $clog2(BIT_CLKS + 1);
  localparam int TMO  = RX_TIMEOUT_BITS * BIT_CLKS;
  localparam int TW   = $clog2(TMO + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int HALF = BIT_CLKS / 2;
  localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
`ifdef NEXT_KBD_RX_MAJORITY_EN
  localparam int RX_CYC0 = 4;  // start qualified on its 4th low cycle, so the bit is already 4 cycles old
  localparam int SAMP    = HALF + 2;
`else
  localparam int RX_CYC0 = 1;
  localparam int SAMP    = HALF;
`endif

  typedef enum logic [2:0] {INIT_GAP, RESET_TX, GAP, LED_TX, POLL_TX, WAIT_RX, RX} state_t;
  state_t state, next;

  logic [CW-1:0] cyc;
  logic [4:0]    nbit;
  logic [TW-1:0] tmo;
  logic [20:0]   tx_sr, tx_frame;
  logic [17:0]   rx_sr;
  logic          s1, s2, rx_bit, start_qual;
  logic [1:0]    idx, idx_nxt;
  logic          led_pend;
  logic [7:0]    led_q;
  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr, rd;
  logic          empty, full, pop, push, bit_end, samp, tx_state;

`ifdef NEXT_KBD_RX_MAJORITY_EN
  logic [2:0] lowcnt;
  logic       v0, v1;
  assign rx_bit     = (v0 & v1) | (v0 & s2) | (v1 & s2);
  assign start_qual = (lowcnt == 3'd3) && !s2;
`else
  logic s3;
  assign rx_bit     = s2;
  assign start_qual = s3 && !s2;
`endif

  assign bit_end   = cyc == CW'(BIT_CLKS - 1);
  assign samp      = (state == RX) && (cyc == CW'(SAMP));
  assign tx_state  = (state == RESET_TX) || (state == LED_TX) || (state == POLL_TX);
  assign idx_nxt   = (idx == 2'(NUM_DEV - 1)) ? 2'd0 : idx + 2'd1;
  assign empty     = wr == rd;
  assign full      = (wr - rd) == DEPTH_P;
  assign evt_valid = !empty;
  assign pop       = evt_valid && evt_ready;
  assign evt_dev   = empty ? 2'd0  : mem[rd[AW-1:0]][17:16];
  assign evt_data  = empty ? 16'd0 : mem[rd[AW-1:0]][15:0];
  assign led_ready = !led_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT_GAP;
    else        state <= next;
  end

  always_comb begin
    next = state;
    push = 1'b0;
    case (state)
      INIT_GAP: if (bit_end && nbit == 5'(GAP_BITS - 1)) next = RESET_TX;
      RESET_TX: if (bit_end && nbit == 5'd20) next = GAP;
      GAP:      if (bit_end && nbit == 5'(GAP_BITS - 1)) next = led_pend ? LED_TX : POLL_TX;
      LED_TX:   if (bit_end && nbit == 5'd20) next = GAP;
      POLL_TX:  if (bit_end && nbit == 5'd8) next = WAIT_RX;
      WAIT_RX:  if (start_qual) next = RX;
                else if (tmo == TW'(TMO - 1)) next = GAP;
      RX:       if (samp) begin
                  if (nbit == 5'd0 && rx_bit) next = WAIT_RX;
                  else if (nbit == 5'd20) begin
                    next = GAP;
                    push = rx_sr[9:8] != 2'b11;  // fA==11 is an empty poll answer
                  end
                end
      default:  next = INIT_GAP;
    endcase
  end

  always_comb begin
    case (next)
      RESET_TX: tx_frame = {1'b0, 8'hFF, 2'b11, 8'h00, 2'b11};
      LED_TX:   tx_frame = {1'b0, 8'h01, 2'b00, led_q, 2'b01};
      default:  tx_frame = {1'b0, 6'b000100, idx, 12'h000};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc <= '0; nbit <= '0; tmo <= '0;
      tx_sr <= '1; to_kb <= 1'b1; s1 <= 1'b1; s2 <= 1'b1; rx_sr <= '0;
      idx <= '0; dev_present <= '0; led_pend <= 1'b0; led_q <= '0;
      wr <= '0; rd <= '0; fifo_overflow <= 1'b0;
`ifdef NEXT_KBD_RX_MAJORITY_EN
      lowcnt <= '0; v0 <= 1'b1; v1 <= 1'b1;
`else
      s3 <= 1'b1;
`endif
    end else begin
      s1 <= from_kb;
      s2 <= s1;
`ifdef NEXT_KBD_RX_MAJORITY_EN
      if (s2) lowcnt <= '0;
      else if (lowcnt != 3'd4) lowcnt <= lowcnt + 3'd1;
      if (state == RX && cyc == CW'(HALF - 2)) v0 <= s2;
      if (state == RX && cyc == CW'(HALF))     v1 <= s2;
`else
      s3 <= s2;
`endif
      if (next != state) begin
        cyc  <= (next == RX) ? CW'(RX_CYC0) : '0;
        nbit <= '0;
      end else begin
        cyc <= bit_end ? '0 : cyc + CW'(1);
        if (state == RX ? samp : bit_end) nbit <= nbit + 5'd1;
      end
      // timeout restarts per query only; a rejected glitch keeps the elapsed time
      if (state == POLL_TX)      tmo <= '0;
      else if (state == WAIT_RX) tmo <= tmo + TW'(1);

      if (next != state && (next == RESET_TX || next == LED_TX || next == POLL_TX)) begin
        to_kb <= tx_frame[20];
        tx_sr <= {tx_frame[19:0], 1'b1};
      end else if (next != state) begin
        to_kb <= 1'b1;
      end else if (tx_state && bit_end) begin
        to_kb <= tx_sr[20];
        tx_sr <= {tx_sr[19:0], 1'b1};
      end

      if (samp && nbit >= 5'd1 && nbit <= 5'd18) rx_sr <= {rx_sr[16:0], rx_bit};

      if ((state == WAIT_RX || state == RX) && next == GAP) begin
        idx <= idx_nxt;
        for (int d = 0; d < NUM_DEV; d++)
          if (idx == 2'(d)) dev_present[d] <= (state == RX);
      end

      if (led_valid && !led_pend) begin
        led_pend <= 1'b1;
        led_q    <= 8'(led_data);
      end else if (state == LED_TX && next == GAP) begin
        led_pend <= 1'b0;
      end

      if (push && (!full || pop)) wr <= wr + PTR_ONE;
      if (push && full && !pop)   fifo_overflow <= 1'b1;
      if (pop) rd <= rd + PTR_ONE;
    end
  end

  always_ff @(posedge clk)
    if (rst_n && push && (!full || pop)) mem[wr[AW-1:0]] <= {idx, rx_sr[17:10], rx_sr[7:0]};

endmodule

// File: doc/next_kbd_link.md
Name: next_kbd_link

Overview:
- Parametrised successor to the NeXT keyboard/mouse serial link controller.
- Owns the single bidirectional-pair serial link (to_kb/from_kb) and polls up to NUM_DEV devices round-robin.
- Sends LED commands and buffers received events in a FIFO with a valid/ready handshake toward the ASIC register interface.
- Tracks per-device presence via response timeouts.

Parameters:
- BIT_CLKS, 265, clk cycles per serial bit (53 us at 5 MHz).
- NUM_DEV, 2, polled devices, 1..4; index 0 keyboard, 1 mouse.
- FIFO_DEPTH, 4, event FIFO entries, power of two, 2..16.
- LED_W, 2, LED bits, 1..8.
- GAP_BITS, 3, idle-high bit times between frames.
- RX_TIMEOUT_BITS, 16, bit times after query end with no start bit before the device is declared absent.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- led_valid  in  1  LED update request
- led_data  in  LED_W  LED state
- led_ready  out  1  high when no LED frame is pending
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer pops head when evt_valid&evt_ready
- evt_dev  out  2  device index of head event
- evt_data  out  16  {byteA,byteB} of head event
- fifo_overflow  out  1  sticky; an event was dropped
- dev_present  out  NUM_DEV  device answered its last query
- from_kb  in  1  serial in, idle high, asynchronous
- to_kb  out  1  serial out, idle high

Behaviour:
- Reset values: to_kb=1, led_ready=1, evt_valid=0, evt_dev=0, evt_data=0, fifo_overflow=0, dev_present=0, FIFO empty, poll index=0.
- from_kb passes through a 2-FF synchroniser before use.
- Frames are sent MSB first; each bit is held for BIT_CLKS cycles.
  - Reset frame (21 bits): {0, 8'hFF, 2'b11, 8'h00, 2'b11}.
  - Query frame (9 bits): {0, 6'b000100, dev[1:0]}.
  - LED frame (21 bits): {0, 8'h01, 2'b00, zero-extended led[7:0], 2'b01}.
- Response frame (21 bits): {0, A[8], fA[2], B[8], fB[2]}.
- FSM states: INIT_GAP -> RESET_TX -> GAP -> (LED_TX if LED pending, else POLL_TX) -> WAIT_RX -> RX -> GAP. LED_TX returns to GAP.
  - INIT_GAP lasts GAP_BITS bit times after rst_n goes high.
  - GAP always lasts GAP_BITS bit times.
- WAIT_RX:
  - Synchronised falling edge of from_kb -> RX.
  - No start bit within RX_TIMEOUT_BITS*BIT_CLKS cycles -> clear dev_present[idx], advance idx, go to GAP.
- RX:
  - First sample at BIT_CLKS/2 after the edge, then every BIT_CLKS.
  - If the start-bit sample reads 1, the frame is a glitch: return to WAIT_RX with the timeout counter not restarted.
  - After the 21st sample: set dev_present[idx].
  - If fA!=2'b11, push {idx, A, B} into the FIFO. fA==2'b11 means "no data"; nothing is pushed.
  - Advance idx (wraps NUM_DEV-1 -> 0), go to GAP.
- FIFO:
  - First-word fall-through; evt_valid rises the cycle after the last RX sample.
  - When full and no pop in the same cycle, the event is dropped and fifo_overflow is set; it clears only on reset.
  - When full with a simultaneous pop, the push is accepted.
- LED handshake:
  - led_valid&led_ready latches led_data; led_ready drops the next cycle and rises on the cycle after LED_TX's last bit ends.
  - led_valid while led_ready=0 is ignored; there is no queueing.
  - A latched LED frame is sent at the next GAP exit, preempting the poll; idx is not advanced.
- to_kb is driven from a register and is glitch-free.
- Reset asserted mid-frame: the next edge forces all reset values, the FIFO is emptied, and the sequence restarts at INIT_GAP.

Optional Feature:
- Macro: NEXT_KBD_RX_MAJORITY_EN.
- Defined: each RX bit is the majority of three samples at BIT_CLKS/2-2, BIT_CLKS/2 and BIT_CLKS/2+2 within the bit; the start edge must stay low 4 cycles to qualify.
- Undefined: a single sample at BIT_CLKS/2 per bit, and any synchronised falling edge qualifies.

Test Plan:
- Release reset, from_kb idle -> 3*265 cycles high, then the 21-bit reset frame on to_kb; dev_present stays 0 after timeouts.
- Query dev0, reply 21'b000000000110000000001 -> no event, dev_present[0]=1, next query carries dev=1.
- Query dev0, reply 21'b011011001010000000010 -> evt_valid with evt_dev=0, evt_data=16'hD900 (A=8'hD9, B=8'h00).
- Hold evt_ready=0 with FIFO_DEPTH=4, send 5 data replies -> 4 entries retained in order, fifo_overflow=1; then pop all -> evt_valid=0.
- led_data=2'b11 with a one-cycle led_valid -> led_ready=0; next frame on to_kb is {0,8'h01,00,8'h03,01}; led_ready returns to 1 afterward.
- Pulse rst_n low mid-RX -> to_kb=1 and evt_valid=0 the next cycle, then the reset frame is sent again; with the macro defined, a 2-cycle low glitch in WAIT_RX is rejected.
